seg7_scan_driver: RTL and testbench

Consumer end of the stopwatch digit bus: takes packed BCD digits from the timing counters and drives a time-multiplexed common-anode 7-segment display. Contains a refresh prescaler, a digit-scan counter, a frame-coherent shadow register and a registered segment decoder. Sits between the counter chain and the board display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 24 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_driver.sv | 95 +++++++++
 tb/tb_seg7_scan_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: BCD digit width and segment patterns (bit0=a .. bit6=g).
package seg7_scan_driver_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_out_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high segment pattern; 10-15 render as a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-coherent digit shadow.
// Optional leading-zero blanking under SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGIT_REGS     = DIGIT_W,
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_DIGITS*DIGIT_REGS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic                            enable,
  output logic [6:0]                      seg,
  output logic                            dp,
  output logic [NUM_DIGITS-1:0]           an,
  output logic                            frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          POL    = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]                         presc;
  logic [IW-1:0]                         idx;
  logic [NUM_DIGITS-1:0][DIGIT_REGS-1:0] shadow;
  logic [NUM_DIGITS-1:0]                 dp_sh;
  logic                                  tick;
  logic [NUM_DIGITS-1:0]                 an_nxt;
  logic [6:0]                            dec;
  logic                                  blank;
  seg_out_t                              out_r;
  logic [NUM_DIGITS-1:0]                 an_r;

  assign tick = (presc == P_LAST);

  always_comb begin
    an_nxt      = '0;
    an_nxt[idx] = 1'b1;
  end

  bcd_to_seg7 u_dec (
    .bcd (shadow[idx][DIGIT_W-1:0]),
    .seg (dec)
  );

`ifdef SEG7_LZ_BLANK_EN
  // lz[i]: digit i and everything above it is zero in the shadow.
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (shadow[NUM_DIGITS-1] == '0);
    for (int i = NUM_DIGITS-2; i >= 0; i--)
      lz[i] = lz[i+1] & (shadow[i] == '0);
  end
  assign blank = (idx != '0) & lz[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      shadow      <= '0;
      dp_sh       <= '0;
      frame_start <= 1'b0;
      an_r        <= '0;
      out_r       <= '0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= tick && (idx == I_LAST);
      if (tick) begin
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
        // Capture only at frame wrap so a frame never mixes old and new digits.
        if (idx == I_LAST) begin
          shadow <= bcd_in;
          dp_sh  <= dp_in;
        end
      end
      an_r      <= enable ? an_nxt : '0;
      out_r.seg <= (enable && !blank) ? dec : SEG_OFF;
      out_r.dp  <= enable && !blank && dp_sh[idx];
    end
  end

  assign seg = out_r.seg ^ {7{POL}};
  assign dp  = out_r.dp ^ POL;
  assign an  = an_r ^ {NUM_DIGITS{POL}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-count arithmetic model.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]  dp_in;
  logic          enable;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_start;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [4*N-1:0] m_sh;
  logic [N-1:0]   m_dp;

  seg7_scan_driver #(
    .DIGIT_REGS(4), .NUM_DIGITS(N), .REFRESH_DIV(D), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .enable(enable),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: pat = 7'h3F;  4'd1: pat = 7'h06;  4'd2: pat = 7'h5B;
      4'd3: pat = 7'h4F;  4'd4: pat = 7'h66;  4'd5: pat = 7'h6D;
      4'd6: pat = 7'h7D;  4'd7: pat = 7'h07;  4'd8: pat = 7'h7F;
      4'd9: pat = 7'h6F;  default: pat = 7'h40;
    endcase
  endfunction

  task automatic chk_off(input string tag);
    total += 4;
    assert (an === 4'hF) else begin bad++; $error("FAIL %s an got=%b exp=1111", tag, an); end
    assert (seg === 7'h7F) else begin bad++; $error("FAIL %s seg got=%b exp=1111111", tag, seg); end
    assert (dp === 1'b1) else begin bad++; $error("FAIL %s dp got=%b exp=1", tag, dp); end
    assert (frame_start === 1'b0) else begin bad++; $error("FAIL %s fs got=%b exp=0", tag, frame_start); end
  endtask

  // One clock: the digit shown after edge k is the slot index in force before that edge,
  // and the shadow reloads at every multiple of D*N edges.
  task automatic step(input string tag);
    int k, d;
    logic [3:0] v;
    logic [6:0] es;
    logic [N-1:0] ea;
    logic ed, efs, blank;
    k = cyc + 1;
    d = ((k - 1) / D) % N;
    v = m_sh[d*4 +: 4];
    blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    blank = (d > 0) && ((m_sh >> (4*d)) == 0);
`endif
    ea  = enable ? ~(N'(1) << d) : {N{1'b1}};
    es  = (enable && !blank) ? ~pat(v) : 7'h7F;
    ed  = (enable && !blank) ? ~m_dp[d] : 1'b1;
    efs = (k % (D*N)) == 0;
    @(posedge clk);
    if (efs) begin m_sh = bcd_in; m_dp = dp_in; end
    cyc = k;
    #1;
    total += 4;
    assert (an === ea) else begin bad++; $error("FAIL %s an k=%0d got=%b exp=%b", tag, k, an, ea); end
    assert (seg === es) else begin bad++; $error("FAIL %s seg k=%0d got=%b exp=%b", tag, k, seg, es); end
    assert (dp === ed) else begin bad++; $error("FAIL %s dp k=%0d got=%b exp=%b", tag, k, dp, ed); end
    assert (frame_start === efs) else begin bad++; $error("FAIL %s fs k=%0d got=%b exp=%b", tag, k, frame_start, efs); end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100; enable = 1'b1;
    m_sh = '0; m_dp = '0;
    #12;
    chk_off("reset");
    rst = 1'b0;

    // first frame shows zeros, then 1234
    run("scan1234", 40);
    // mid-frame change: rest of this frame keeps 1234
    bcd_in = 16'h5678; dp_in = 4'b0001;
    run("mid5678", 30);
    bcd_in = 16'h00AF; dp_in = 4'b0000;
    run("dash", 36);

    // asynchronous reset mid-slot
    #2 rst = 1'b1;
    #1 chk_off("async_rst");
    @(posedge clk); #1;
    chk_off("rst_hold");
    rst = 1'b0; cyc = 0; m_sh = '0; m_dp = '0;
    bcd_in = 16'h9081; dp_in = 4'b1010;
    run("restart", 20);

    // dark period, index keeps advancing
    enable = 1'b0;
    run("dark", 7);
    enable = 1'b1;
    run("resume", 12);

    bcd_in = 16'h0007; dp_in = 4'b1111;
    run("lz7", 36);
    bcd_in = 16'h0000;
    run("lz0", 36);

    for (int i = 0; i < 200; i++) begin
      if ((i % 5) == 0) bcd_in = 16'($urandom);
      if ((i % 7) == 0) dp_in = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
